// File: rtl/disc_frame_sequencer.sv
// disc_frame_sequencer
//   Wrapper stage around the 9-3-1 discriminator. It collects a serial stream
//   of Q8.8 pixels into 3x3 frames and fires each frame at the discriminator
//   as 9 parallel pixels with a one-cycle start pulse. It then waits for the
//   score and returns it, tagged with a frame index, over a valid/ready port.
//   Malformed frames are dropped, and err_frame pulses once for each drop. If
//   the discriminator does not answer within TIMEOUT cycles, a zero score
//   marked m_timeout is returned in its place.
//
//   Optional build macro DISC_SEQ_THRESH_EN adds parameter THRESH and output
//   m_real (registered signed compare m_score >= THRESH, 0 on timeouts).
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   s_valid/s_ready/s_pix/s_last input pixel stream
//   d_pix, d_valid_in            frame pixels and start pulse to discriminator
//   d_valid_out, d_score         discriminator result
//   m_valid/m_ready/m_score/m_idx/m_timeout  result port
//   err_frame                    one-cycle pulse per dropped frame
module disc_frame_sequencer #(
   parameter int NPIX    = 9,
   parameter int DW      = 16,
   parameter int TIMEOUT = 64,
   parameter int IDX_W   = 16
`ifdef DISC_SEQ_THRESH_EN
  ,parameter logic signed [DW-1:0] THRESH = 16'sh0080
`endif
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [DW-1:0]        s_pix,
   input  logic                 s_last,
   output logic [NPIX*DW-1:0]   d_pix,
   output logic                 d_valid_in,
   input  logic                 d_valid_out,
   input  logic [DW-1:0]        d_score,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [DW-1:0]        m_score,
   output logic [IDX_W-1:0]     m_idx,
   output logic                 m_timeout,
   output logic                 err_frame
`ifdef DISC_SEQ_THRESH_EN
  ,output logic                 m_real
`endif
);

   localparam int CNT_W = $clog2(NPIX);
   localparam int TW    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NPIX - 1);
   localparam logic [TW-1:0]    T_LAST   = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {COLLECT, RESYNC, FIRE, WAIT, OUT} state_t;

   state_t                  state, state_n;
   logic [CNT_W-1:0]        cnt;
   logic [TW-1:0]           tcnt;
   logic [NPIX-1:0][DW-1:0] slot;
   logic                    drop, capture, tmo;

   // Slots are only written while collecting, so d_pix holds still from
   // FIRE until WAIT exits.
   assign d_pix = slot;

   always_ff @(posedge clk) begin
      if (rst) state <= COLLECT;
      else     state <= state_n;
   end

   always_comb begin
      state_n    = state;
      s_ready    = 1'b0;
      d_valid_in = 1'b0;
      m_valid    = 1'b0;
      drop       = 1'b0;
      capture    = 1'b0;
      tmo        = 1'b0;
      case (state)
         COLLECT: begin
            s_ready = 1'b1;
            if (s_valid) begin
               if (cnt == CNT_LAST) begin
                  if (s_last) state_n = FIRE;
                  else begin
                     drop    = 1'b1;
                     state_n = RESYNC;
                  end
               end else if (s_last) begin
                  drop = 1'b1;
               end
            end
         end
         RESYNC: begin
            s_ready = 1'b1;
            if (s_valid && s_last) state_n = COLLECT;
         end
         FIRE: begin
            d_valid_in = 1'b1;
            state_n    = WAIT;
         end
         WAIT: begin
            if (d_valid_out) begin
               capture = 1'b1;
               state_n = OUT;
            end else if (tcnt == T_LAST) begin
               tmo     = 1'b1;
               state_n = OUT;
            end
         end
         OUT: begin
            m_valid = 1'b1;
            if (m_ready) state_n = COLLECT;
         end
         default: state_n = COLLECT;
      endcase
      // Keep the handshake outputs quiet while reset is held.
      if (rst) begin
         s_ready    = 1'b0;
         d_valid_in = 1'b0;
         m_valid    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         tcnt      <= '0;
         slot      <= '0;
         m_score   <= '0;
         m_idx     <= '0;
         m_timeout <= 1'b0;
         err_frame <= 1'b0;
`ifdef DISC_SEQ_THRESH_EN
         m_real    <= 1'b0;
`endif
      end else begin
         err_frame <= drop;
         case (state)
            COLLECT: begin
               if (s_valid) begin
                  for (int k = 0; k < NPIX; k++)
                     if (cnt == CNT_W'(k)) slot[k] <= s_pix;
                  // Any s_last or 9th beat ends this frame, whether it is good or dropped.
                  cnt <= (s_last || cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
               end
            end
            FIRE: tcnt <= '0;
            WAIT: begin
               tcnt <= tcnt + TW'(1);
               if (capture) begin
                  m_score   <= d_score;
                  m_timeout <= 1'b0;
`ifdef DISC_SEQ_THRESH_EN
                  m_real    <= ($signed(d_score) >= THRESH);
`endif
               end else if (tmo) begin
                  m_score   <= '0;
                  m_timeout <= 1'b1;
`ifdef DISC_SEQ_THRESH_EN
                  m_real    <= 1'b0;
`endif
               end
            end
            OUT: begin
               if (m_ready) begin
                  m_idx <= m_idx + IDX_W'(1);
                  cnt   <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_disc_frame_sequencer.sv
module tb_disc_frame_sequencer;
   localparam int NPIX = 9, DW = 16, TIMEOUT = 64, IDX_W = 16;

   logic                clk = 1'b0, rst = 1'b1;
   logic                s_valid, s_ready, s_last;
   logic [DW-1:0]       s_pix;
   logic [NPIX*DW-1:0]  d_pix;
   logic                d_valid_in, d_valid_out;
   logic [DW-1:0]       d_score;
   logic                m_valid, m_ready, m_timeout, err_frame;
   logic [DW-1:0]       m_score;
   logic [IDX_W-1:0]    m_idx;
`ifdef DISC_SEQ_THRESH_EN
   logic                m_real;
`endif

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   disc_frame_sequencer dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_pix(s_pix), .s_last(s_last),
      .d_pix(d_pix), .d_valid_in(d_valid_in),
      .d_valid_out(d_valid_out), .d_score(d_score),
      .m_valid(m_valid), .m_ready(m_ready), .m_score(m_score),
      .m_idx(m_idx), .m_timeout(m_timeout), .err_frame(err_frame)
`ifdef DISC_SEQ_THRESH_EN
     ,.m_real(m_real)
`endif
   );

   typedef struct packed {
      logic [15:0] score;
      logic [15:0] idx;
      logic        tmo;
      logic        rl;
   } res_t;

   res_t               exp_res[$];
   logic [NPIX*DW-1:0] exp_frame[$];
   res_t               mon_r;
   int n_vec = 0, n_err = 0;
   int fire_cnt = 0, fire_cyc = 0, mv_cnt = 0, mv_cyc = 0, err_cnt = 0;
   int acc_cyc = 0, dvo_cyc = 0, e0 = 0;
   logic [15:0] exp_idx = '0;
   bit prev_mv = 1'b0;

   task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic bad(input string nm);
      n_vec++;
      n_err++;
      $display("FAIL %s", nm);
   endtask

   function automatic res_t mk(input logic [15:0] sc, input logic [15:0] ix, input logic t);
      res_t r;
      r.score = sc;
      r.idx   = ix;
      r.tmo   = t;
      r.rl    = !t && ($signed(sc) >= 16'sh0080);
      return r;
   endfunction

   // Monitor: frames on the start pulse, results whenever m_valid is up.
   always @(negedge clk) begin
      if (!rst) begin
         if (d_valid_in) begin
            fire_cnt++;
            fire_cyc = cyc;
            if (exp_frame.size() == 0) bad("unexpected_d_valid_in");
            else chk("d_pix", d_pix, exp_frame.pop_front());
         end
         if (err_frame) err_cnt++;
         if (m_valid && !prev_mv) begin
            mv_cnt++;
            mv_cyc = cyc;
         end
         if (m_valid) begin
            if (exp_res.size() == 0) bad("unexpected_m_valid");
            else begin
               mon_r = exp_res[0];
               chk("m_score", m_score, mon_r.score);
               chk("m_idx", m_idx, mon_r.idx);
               chk("m_timeout", m_timeout, mon_r.tmo);
`ifdef DISC_SEQ_THRESH_EN
               chk("m_real", m_real, mon_r.rl);
`endif
               if (m_ready) void'(exp_res.pop_front());
            end
         end
         prev_mv = m_valid;
      end else begin
         prev_mv = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] p, input logic last);
      int g = 0;
      s_valid = 1'b1;
      s_pix   = p;
      s_last  = last;
      while (!s_ready && g < 100) begin
         tick();
         g++;
      end
      if (!s_ready) bad("s_ready_wait");
      tick();
      acc_cyc = cyc - 1;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic send_frame(input logic [15:0] base, input logic [15:0] step);
      logic [NPIX*DW-1:0] f;
      logic [15:0] p;
      p = base;
      for (int k = 0; k < NPIX; k++) begin
         f[k*DW +: DW] = p;
         p = p + step;
      end
      exp_frame.push_back(f);
      p = base;
      for (int k = 0; k < NPIX; k++) begin
         send(p, k == NPIX - 1);
         p = p + step;
      end
   endtask

   task automatic wait_fire();
      int c0 = fire_cnt;
      int g = 0;
      while (fire_cnt == c0 && g < 50) begin
         tick();
         g++;
      end
      if (fire_cnt == c0) bad("fire_wait");
      else chk("fire_latency", fire_cyc, acc_cyc + 1);
   endtask

   // Called right after wait_fire; dly counts cycles after the start pulse.
   task automatic score_after(input int dly, input logic [15:0] sc);
      repeat (dly - 1) tick();
      exp_res.push_back(mk(sc, exp_idx, 1'b0));
      exp_idx++;
      d_valid_out = 1'b1;
      d_score     = sc;
      dvo_cyc     = cyc;
      tick();
      d_valid_out = 1'b0;
   endtask

   task automatic drain();
      int g = 0;
      while (exp_res.size() != 0 && g < 200) begin
         tick();
         g++;
      end
      if (exp_res.size() != 0) begin
         bad("result_wait");
         exp_res.delete();
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_s_ready"}, s_ready, 0);
      chk({tag, "_d_valid_in"}, d_valid_in, 0);
      chk({tag, "_m_valid"}, m_valid, 0);
      chk({tag, "_m_score"}, m_score, 0);
      chk({tag, "_m_idx"}, m_idx, 0);
      chk({tag, "_m_timeout"}, m_timeout, 0);
      chk({tag, "_err_frame"}, err_frame, 0);
      chk({tag, "_d_pix"}, d_pix, 0);
`ifdef DISC_SEQ_THRESH_EN
      chk({tag, "_m_real"}, m_real, 0);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      s_valid = 0; s_pix = 0; s_last = 0;
      d_valid_out = 0; d_score = 0; m_ready = 1; rst = 1;
      repeat (3) tick();
      chk_reset("por");
      rst = 0;
      tick();
      chk("s_ready_idle", s_ready, 1);

      // Basic frame, score five cycles after the start pulse
      send_frame(16'h0100, 16'h0100);
      wait_fire();
      score_after(5, 16'h00C0);
      drain();
      chk("m_valid_latency", mv_cyc, dvo_cyc + 1);

      // Short frame: s_last on the 4th pixel
      e0 = err_cnt;
      send(16'hAAA1, 0); send(16'hAAA2, 0); send(16'hAAA3, 0); send(16'hAAA4, 1);
      repeat (3) tick();
      chk("err_short", err_cnt - e0, 1);
      send_frame(16'h1000, 16'h0010);
      wait_fire();
      score_after(3, 16'hFF40);
      drain();

      // Long frame: 9 pixels without s_last, then 3 more ending with s_last
      e0 = err_cnt;
      for (int k = 0; k < 9; k++) send(16'hB000 + 16'(k), 0);
      for (int k = 0; k < 3; k++) send(16'hC000 + 16'(k), k == 2);
      repeat (3) tick();
      chk("err_long", err_cnt - e0, 1);
      send_frame(16'h8001, 16'h0101);
      wait_fire();
      score_after(1, 16'h7FFF);
      drain();

      // Discriminator never answers
      send_frame(16'h0F00, 16'hFFFF);
      wait_fire();
      exp_res.push_back(mk(16'h0000, exp_idx, 1'b1));
      exp_idx++;
      drain();
      chk("timeout_latency", mv_cyc - fire_cyc, TIMEOUT + 1);

      // Back-pressure: result held for 20 cycles, stray score ignored
      m_ready = 0;
      send_frame(16'h0011, 16'h0022);
      wait_fire();
      score_after(2, 16'h1234);
      tick();
      for (int i = 0; i < 20; i++) begin
         chk("hold_s_ready", s_ready, 0);
         chk("hold_m_valid", m_valid, 1);
         if (i == 5) begin
            d_valid_out = 1'b1;
            d_score     = 16'h5555;
         end
         if (i == 6) d_valid_out = 1'b0;
         tick();
      end
      m_ready = 1;
      drain();
      send_frame(16'h2000, 16'h0003);
      wait_fire();
      score_after(4, 16'h0101);
      drain();

      // Reset while waiting for the score; a late score must be ignored
      send_frame(16'h0500, 16'h0001);
      wait_fire();
      repeat (3) tick();
      rst = 1;
      tick();
      chk_reset("wait_rst");
      rst = 0;
      exp_idx = '0;
      tick();
      d_valid_out = 1'b1;
      d_score     = 16'h4444;
      tick();
      d_valid_out = 1'b0;
      repeat (10) tick();
      chk("s_ready_after_rst", s_ready, 1);

      // Threshold boundary scores, index restarts at 0
      send_frame(16'h0300, 16'h0100);
      wait_fire();
      score_after(2, 16'h0080);
      drain();
      send_frame(16'h0700, 16'h0010);
      wait_fire();
      score_after(6, 16'h007F);
      drain();
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/disc_frame_sequencer.md
Name: disc_frame_sequencer

Overview:
- Upstream/downstream wrapper stage for the 9-3-1 discriminator.
- Accepts a serial stream of Q8.8 pixels and assembles 3x3 frames of 9 pixels each.
- For each frame, presents the 9 pixels in parallel with a one-cycle start pulse, then waits for the discriminator's score.
- Returns the score, tagged with a frame index, over a valid/ready output port.
- Handles frame-framing errors and discriminator timeouts.

Parameters:
- NPIX, 9, pixels per frame (fixed by the discriminator; other values unsupported).
- DW, 16, pixel/score width, Q8.8 signed.
- TIMEOUT, 64, maximum cycles to wait for d_valid_out after the start pulse.
- IDX_W, 16, frame index counter width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  input pixel ready.
- s_pix  in  DW  input pixel, Q8.8 signed.
- s_last  in  1  marks the 9th pixel of a frame.
- d_pix  out  NPIX*DW  frame pixels; pixel k at bits [16k+15:16k], k=0 is the first accepted pixel (maps to i_pix1).
- d_valid_in  out  1  one-cycle start pulse to the discriminator.
- d_valid_out  in  1  discriminator score valid.
- d_score  in  DW  discriminator score, Q8.8.
- m_valid  out  1  result valid.
- m_ready  in  1  result ready.
- m_score  out  DW  captured score.
- m_idx  out  IDX_W  frame index of this result.
- m_timeout  out  1  result is a timeout substitute, not a real score.
- err_frame  out  1  one-cycle pulse on each dropped frame.

Behaviour:
- Reset values: s_ready=0, d_pix=0, d_valid_in=0, m_valid=0, m_score=0, m_idx=0, m_timeout=0, err_frame=0. State COLLECT, pixel count=0, index counter=0. Reset mid-operation aborts any frame; a late d_valid_out after reset is ignored.
- States: COLLECT, RESYNC, FIRE, WAIT, OUT.
- COLLECT:
  - s_ready=1. Each s_valid&s_ready stores s_pix into slot cnt, then cnt++.
  - Accept with cnt==8 and s_last=1: go to FIRE.
  - Accept with s_last=1 and cnt<8: drop the frame, pulse err_frame, cnt=0, stay in COLLECT.
  - Accept with cnt==8 and s_last=0: drop the frame, pulse err_frame, go to RESYNC.
- RESYNC:
  - s_ready=1. Discard pixels until a beat with s_last=1 is accepted, then go to COLLECT with cnt=0.
- FIRE:
  - s_ready=0. d_valid_in=1 for exactly this cycle. Latency: last pixel accepted in cycle N gives d_valid_in in cycle N+1.
  - Go to WAIT with the timeout counter cleared.
- d_pix stability: held constant from FIRE until exit from WAIT (the activation stages re-sample combinational sums). Slots are written only in COLLECT.
- WAIT:
  - s_ready=0.
  - d_valid_out=1: capture d_score into m_score, m_timeout=0, go to OUT. m_valid rises in the next cycle.
  - Timeout counter reaches TIMEOUT-1 with no d_valid_out: m_score=0x0000, m_timeout=1, go to OUT.
  - d_valid_out arriving in FIRE, COLLECT, RESYNC or OUT is ignored.
- OUT:
  - m_valid=1. m_score, m_idx and m_timeout stay stable until m_ready.
  - On handshake: m_valid=0, index counter increments (wraps 2^IDX_W-1 to 0), cnt=0, go to COLLECT.
  - s_ready=0 in OUT; there is no overlap of collection and output.
- m_idx counts only emitted results, including timeouts. Dropped frames do not consume an index.
- No arithmetic on scores; values pass through bit-exact.

Optional Feature:
- Macro: DISC_SEQ_THRESH_EN.
- With the macro: extra output m_real (1 bit) and parameter THRESH (default 16'sh0080, i.e. 0.5). m_real = (m_score >= THRESH) as a signed compare, registered with m_score. It is forced 0 when m_timeout=1, and is 0 at reset.
- Without the macro: the port and parameter do not exist; all other behaviour is identical.

Test Plan:
- Nine back-to-back pixels 0x0100..0x0900, s_last on the 9th. Expect d_valid_in one cycle after the 9th accept, d_pix slot0=0x0100 and slot8=0x0900. Drive d_valid_out with d_score=0x00C0 five cycles later. Expect m_valid next cycle with m_score=0x00C0, m_idx=0, m_timeout=0.
- s_last on the 4th pixel. Expect an err_frame pulse, no d_valid_in, then a full 9-pixel frame processes normally with m_idx=0.
- Nine pixels with no s_last, then 3 more pixels with s_last on the 3rd. Expect one err_frame pulse, all 12 pixels discarded, no d_valid_in; the next good frame is accepted.
- d_valid_out never asserted. Expect m_valid exactly TIMEOUT+1 cycles after d_valid_in, with m_score=0x0000 and m_timeout=1.
- m_ready held low for 20 cycles in OUT. Expect m_* stable, s_ready=0, and a stray d_valid_out ignored. Then m_ready=1 gives m_idx=1 on the next frame.
- Reset asserted during WAIT. Expect all outputs at reset values next cycle; a d_valid_out arriving afterwards produces no m_valid. With DISC_SEQ_THRESH_EN: score 0x0080 gives m_real=1, score 0x007F gives m_real=0.
